// File: rtl/decod_strobe.sv
// decod_strobe: clocked select/enable decoder with a valid/ready request port.
// An accepted request drives a registered one-hot word for STROBE_LEN cycles,
// pulses out_done once, then holds all outputs low for GAP_CYC dead cycles.
// Optional macro DECOD_STROBE_PEND_EN adds a one-entry pending slot so the next
// request can be queued during a strobe/gap and launched without an idle cycle.
module decod_strobe #(
    parameter int SEL_W      = 4,
    parameter int STROBE_LEN = 3,
    parameter int GAP_CYC    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_en,
    output logic [(2**SEL_W)-1:0] out_onehot,
    output logic                  out_active,
    output logic                  out_done
);

    localparam int OUT_W   = 2**SEL_W;
    localparam int MAX_CNT = (STROBE_LEN > GAP_CYC) ? STROBE_LEN : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] onehot_q, onehot_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             accept;

    // A disabled request still strobes, just with every line low.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel, input logic en);
        logic [OUT_W-1:0] word;
        word = '0;
        if (en) word[sel] = 1'b1;
        return word;
    endfunction

`ifdef DECOD_STROBE_PEND_EN
    logic             pend_vld_q, pend_vld_d;
    logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
    logic             pend_en_q, pend_en_d;
    logic             to_idle;

    // The edge where the block would otherwise fall back to IDLE.
    assign to_idle  = ((state_q == ACTIVE) && (cnt_q == '0) && (GAP_CYC == 0)) ||
                      ((state_q == GAP) && (cnt_q == '0));
    assign in_ready = (state_q == IDLE) || !pend_vld_q;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid && in_ready;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        active_d = active_q;
        done_d   = 1'b0;
`ifdef DECOD_STROBE_PEND_EN
        pend_vld_d = pend_vld_q;
        pend_sel_d = pend_sel_q;
        pend_en_d  = pend_en_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ACTIVE;
                    cnt_d    = STROBE_LOAD;
                    onehot_d = decode(in_sel, in_en);
                    active_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    onehot_d = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef DECOD_STROBE_PEND_EN
        // A queued request (or one arriving on the same edge) skips IDLE entirely.
        if (to_idle && pend_vld_q) begin
            state_d    = ACTIVE;
            cnt_d      = STROBE_LOAD;
            onehot_d   = decode(pend_sel_q, pend_en_q);
            active_d   = 1'b1;
            pend_vld_d = 1'b0;
        end else if (to_idle && accept) begin
            state_d  = ACTIVE;
            cnt_d    = STROBE_LOAD;
            onehot_d = decode(in_sel, in_en);
            active_d = 1'b1;
        end else if (accept && (state_q != IDLE)) begin
            pend_vld_d = 1'b1;
            pend_sel_d = in_sel;
            pend_en_d  = in_en;
        end
`endif
    end

    // State, counter and output registers; reset clears outputs without an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

`ifdef DECOD_STROBE_PEND_EN
    // Pending-request slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_sel_q <= '0;
            pend_en_q  <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_sel_q <= pend_sel_d;
            pend_en_q  <= pend_en_d;
        end
    end

    // With a one-cycle period, back-to-back done pulses are legitimate.
    localparam bit DONE_BURST = ((STROBE_LEN + GAP_CYC) == 1);
`else
    localparam bit DONE_BURST = 1'b0;
`endif

    assign out_onehot = onehot_q;
    assign out_active = active_q;
    assign out_done   = done_q;

    a_onehot_needs_active: assert property (@(posedge clk) disable iff (rst)
        (onehot_q != '0) |-> active_q);
    a_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(onehot_q));
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        (done_q && !DONE_BURST) |=> !done_q);

endmodule

// File: tb/tb_decod_strobe.sv
// Directed testbench for decod_strobe: default instance plus a
// STROBE_LEN=1 / GAP_CYC=0 instance for the edge-parameter case.
module tb_decod_strobe;

`ifdef DECOD_STROBE_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready, a_en, a_active, a_done;
    logic [3:0]  a_sel;
    logic [15:0] a_onehot;
    logic        e_valid, e_ready, e_en, e_active, e_done;
    logic [3:0]  e_sel;
    logic [15:0] e_onehot;

    int tests;
    int fails;

    decod_strobe #(.SEL_W(4), .STROBE_LEN(3), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_sel(a_sel), .in_en(a_en), .out_onehot(a_onehot),
        .out_active(a_active), .out_done(a_done)
    );

    decod_strobe #(.SEL_W(4), .STROBE_LEN(1), .GAP_CYC(0)) dut_e (
        .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(e_ready),
        .in_sel(e_sel), .in_en(e_en), .out_onehot(e_onehot),
        .out_active(e_active), .out_done(e_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 1'b0; a_sel = '0; a_en = 1'b0;
        e_valid = 1'b0; e_sel = '0; e_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (a_onehot !== 16'h0000) begin fails++; $display("FAIL reset_onehot: got %h expected 0000", a_onehot); end
        tests++; if (a_active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", a_active); end
        tests++; if (a_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", a_done); end
        #4 rst = 1'b0;
        tick();
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
        tests++; if (e_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_e: got %b expected 1", e_ready); end
        tests++; if (a_onehot !== 16'h0000) begin fails++; $display("FAIL reset_onehot_after: got %h expected 0000", a_onehot); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_oh;
        logic        exp_act, exp_done, exp_rdy;
        a_sel = 4'd5; a_en = 1'b1; a_valid = 1'b1;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL basic_ready0: got %b expected 1", a_ready); end
        tick();
        a_valid = 1'b0; a_sel = 4'd0;
        for (int c = 1; c <= 6; c++) begin
            exp_oh   = (c <= 3) ? 16'h0020 : 16'h0000;
            exp_act  = (c <= 3);
            exp_done = (c == 4);
            exp_rdy  = PEND ? 1'b1 : (c == 6);
            tests++; if (a_onehot !== exp_oh) begin fails++; $display("FAIL basic_onehot c%0d: got %h expected %h", c, a_onehot, exp_oh); end
            tests++; if (a_active !== exp_act) begin fails++; $display("FAIL basic_active c%0d: got %b expected %b", c, a_active, exp_act); end
            tests++; if (a_done !== exp_done) begin fails++; $display("FAIL basic_done c%0d: got %b expected %b", c, a_done, exp_done); end
            tests++; if (a_ready !== exp_rdy) begin fails++; $display("FAIL basic_ready c%0d: got %b expected %b", c, a_ready, exp_rdy); end
            if (c < 6) tick();
        end
    endtask

    task automatic test_disabled();
        logic exp_act, exp_done;
        a_sel = 4'd9; a_en = 1'b0; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; a_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            exp_act  = (c <= 3);
            exp_done = (c == 4);
            tests++; if (a_onehot !== 16'h0000) begin fails++; $display("FAIL dis_onehot c%0d: got %h expected 0000", c, a_onehot); end
            tests++; if (a_active !== exp_act) begin fails++; $display("FAIL dis_active c%0d: got %b expected %b", c, a_active, exp_act); end
            tests++; if (a_done !== exp_done) begin fails++; $display("FAIL dis_done c%0d: got %b expected %b", c, a_done, exp_done); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        a_sel = 4'd15; a_en = 1'b1; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tests++; if (a_onehot !== 16'h8000) begin fails++; $display("FAIL mid_onehot1: got %h expected 8000", a_onehot); end
        tick();
        tests++; if (a_onehot !== 16'h8000) begin fails++; $display("FAIL mid_onehot2: got %h expected 8000", a_onehot); end
        #2 rst = 1'b1;
        #1;
        tests++; if (a_onehot !== 16'h0000) begin fails++; $display("FAIL mid_async_onehot: got %h expected 0000", a_onehot); end
        tests++; if (a_active !== 1'b0) begin fails++; $display("FAIL mid_async_active: got %b expected 0", a_active); end
        #2 rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            tests++; if (a_done !== 1'b0) begin fails++; $display("FAIL mid_no_done c%0d: got %b expected 0", c, a_done); end
            tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL mid_ready c%0d: got %b expected 1", c, a_ready); end
        end
        a_sel = 4'd2; a_en = 1'b1; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tests++; if (a_onehot !== 16'h0004) begin fails++; $display("FAIL mid_next_onehot: got %h expected 0004", a_onehot); end
        repeat (8) tick();
    endtask

    task automatic test_held();
        logic [15:0] exp_oh;
        a_sel = 4'd3; a_en = 1'b1; a_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (PEND) exp_oh = (((c - 1) % 5) < 3) ? 16'h0008 : 16'h0000;
            else      exp_oh = (((c - 1) % 6) < 3) ? 16'h0008 : 16'h0000;
            tests++; if (a_onehot !== exp_oh) begin fails++; $display("FAIL held_onehot c%0d: got %h expected %h", c, a_onehot, exp_oh); end
            tests++; if (a_active !== (exp_oh != 16'h0000)) begin fails++; $display("FAIL held_active c%0d: got %b expected %b", c, a_active, (exp_oh != 16'h0000)); end
        end
        a_valid = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_edge();
        int          sel_at [0:6];
        logic [15:0] exp_oh [0:6];
        logic        exp_dn [0:6];
`ifdef DECOD_STROBE_PEND_EN
        sel_at = '{0, 1, 2, -1, -1, -1, -1};
        exp_oh = '{16'h0001, 16'h0002, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp_dn = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        sel_at = '{0, 1, 1, 2, 2, -1, -1};
        exp_oh = '{16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'h0004, 16'h0000, 16'h0000};
        exp_dn = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        e_en = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            e_valid = (sel_at[c] >= 0);
            e_sel   = (sel_at[c] >= 0) ? 4'(sel_at[c]) : 4'd0;
            tick();
            tests++; if (e_onehot !== exp_oh[c]) begin fails++; $display("FAIL edge_onehot c%0d: got %h expected %h", c + 1, e_onehot, exp_oh[c]); end
            tests++; if (e_done !== exp_dn[c]) begin fails++; $display("FAIL edge_done c%0d: got %b expected %b", c + 1, e_done, exp_dn[c]); end
            tests++; if (e_active !== (exp_oh[c] != 16'h0000)) begin fails++; $display("FAIL edge_active c%0d: got %b expected %b", c + 1, e_active, (exp_oh[c] != 16'h0000)); end
        end
        e_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        tick();
        test_disabled();
        test_reset_mid();
        test_held();
        test_edge();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decod_strobe.md
Name: decod_strobe

Overview:
- Parametrised, clocked successor to the team's 4-to-16 enable-gated decoder.
- Accepts a select/enable request over a valid/ready handshake and drives a registered one-hot word for a programmable number of cycles.
- After the strobe it enforces a programmable dead-time before the next request.
- Sits between a command sequencer and per-line strobe consumers (row/bank/channel selects).

Parameters:
- SEL_W, 4: select width; output width OUT_W = 2**SEL_W (derived, not overridable).
- STROBE_LEN, 3: cycles the one-hot word is driven per request; legal range 1..255.
- GAP_CYC, 2: dead cycles (all outputs low) after each strobe; legal range 0..255.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_sel  in  SEL_W  line to strobe.
- in_en  in  1  request enable; 0 = strobe with all lines low.
- out_onehot  out  OUT_W  registered one-hot strobe word.
- out_active  out  1  high for every strobe cycle, including disabled requests.
- out_done  out  1  one-cycle pulse after the last strobe cycle.

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high.
- While rst is high: state=IDLE, counter=0, out_onehot=0, out_active=0, out_done=0, pending slot empty. in_ready=1 after reset release.
- Reset mid-operation clears all outputs immediately, without waiting for an edge. Any in-flight or pending request is dropped.
- All outputs are registered, except in_ready, which is decoded from state only (no combinational path from in_valid).
- Accept = in_valid & in_ready at a rising edge.
- States:
  - IDLE: in_ready=1. On accept: load out_onehot = in_en ? (1 << in_sel) : 0, set out_active=1, cnt=STROBE_LEN-1, go to ACTIVE.
  - ACTIVE: in_ready=0; out_onehot and out_active held. If cnt!=0, decrement cnt. If cnt==0 (last strobe cycle), at the next edge clear out_onehot and out_active, set out_done=1, then:
    - GAP_CYC>0: cnt=GAP_CYC-1, go to GAP.
    - GAP_CYC=0: go to IDLE.
  - GAP: in_ready=0; outputs low except the out_done pulse in its first cycle. Decrement cnt; at cnt==0 go to IDLE.
- Latency: accept at edge k gives out_onehot valid for cycles k+1 .. k+STROBE_LEN exactly. out_done is high in cycle k+STROBE_LEN+1. in_ready returns in cycle k+STROBE_LEN+GAP_CYC+1.
- Max throughput without the optional feature: one request per STROBE_LEN+GAP_CYC+1 cycles.
- in_sel and in_en are sampled only at accept. Changes at any other time are ignored.
- out_onehot has at most one bit set. With in_en=0 it is zero while out_active is still 1.
- Counter width: $clog2(max(STROBE_LEN,GAP_CYC)+1); no wrap is possible within the legal ranges.
- Assertions:
  - out_onehot nonzero implies out_active.
  - $onehot0(out_onehot).
  - out_done is never high for two consecutive cycles.

Optional Feature:
- Macro: DECOD_STROBE_PEND_EN.
- Defined: adds a one-entry pending slot.
  - in_ready = IDLE or slot empty.
  - A request accepted in ACTIVE or GAP is stored in the slot.
  - At the edge where GAP would go to IDLE (or ACTIVE would go to IDLE when GAP_CYC=0), the pending request loads straight into ACTIVE.
  - Back-to-back throughput: one request per STROBE_LEN+GAP_CYC cycles.
  - out_done still pulses for each strobe.
  - rst empties the slot.
- Undefined: no slot; in_ready=0 outside IDLE; behaviour exactly as above.

Test Plan:
- Reset: assert rst mid-cycle -> out_onehot=16'h0000, out_active=0, out_done=0 immediately; in_ready=1 after release.
- Basic strobe (defaults): sel=5, en=1 accepted at edge k -> out_onehot=16'h0020 in cycles k+1..k+3, out_done=1 in k+4 only, in_ready=0 until k+6 then 1.
- Disabled request: sel=9, en=0 -> out_onehot=16'h0000 with out_active=1 for exactly 3 cycles, then out_done pulse.
- Reset mid-strobe: sel=15 accepted, rst in 2nd active cycle -> out_onehot drops from 16'h8000 to 0 asynchronously, no out_done, next request accepted normally.
- Held in_valid (macro undefined): in_valid held high with sel=3 throughout -> accepts only every 6 cycles; 16'h0008 driven 3 of every 6 cycles. With DECOD_STROBE_PEND_EN: second sel=3 accepted during ACTIVE, new strobe starts exactly 5 cycles after the first.
- Edge parameters: STROBE_LEN=1, GAP_CYC=0, requests sel=0,1,2 -> 16'h0001, 16'h0002, 16'h0004, each 1 cycle with an idle cycle between. No idle cycle with the macro defined.
